gru_param_reader: RTL and testbench

GRU_PARAM_READER -- requirements
Module: gru_param_reader

---
 rtl/gru_param_reader.sv | 162 ++++++++++++++++
 tb/tb_gru_param_reader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gru_param_reader.sv
// Streams the GRU bias, input-weight and recurrent-weight words out of parameter memory in address
// order, tagging each word with its segment and index, through a 2-entry output FIFO.
module gru_param_reader #(
  parameter int unsigned FLOAT  = 32,
  parameter int unsigned N_BIAS = 72,
  parameter int unsigned N_IN   = 1728,
  parameter int unsigned N_REC  = 1728,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [FLOAT-1:0]  mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FLOAT-1:0]  out_data,
  output logic [1:0]        out_seg,
  output logic [10:0]       out_idx,
  output logic              out_seg_last,
  output logic              out_last
);

  localparam int unsigned Total = N_BIAS + N_IN + N_REC;
  localparam logic [ADDR_W-1:0] SegBase1 = ADDR_W'(N_BIAS);
  localparam logic [ADDR_W-1:0] SegBase2 = ADDR_W'(N_BIAS + N_IN);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(Total - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StFin} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [FLOAT-1:0]  fifo_data_q [2];
  logic [FLOAT-1:0]  fifo_data_d [2];
  logic [ADDR_W-1:0] fifo_addr_q [2];
  logic [ADDR_W-1:0] fifo_addr_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  logic              pop;
  logic              issue;
  logic [2:0]        occ;
  logic [ADDR_W-1:0] head_addr;

  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: if (issue && (addr_q == LastAddr)) state_d = StDrain;
      StDrain: if (pop && out_last) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin : fsm_out
    busy      = (state_q != StIdle);
    done      = (state_q == StFin);
    mem_rd_en = issue;
    mem_addr  = addr_q;
  end

  // Occupancy counts the word returning this cycle so the FIFO can never be overrun.
  always_comb begin : issue_ctl
    pop   = out_valid & out_ready;
    occ   = 3'(count_q) + 3'(rd_vld_q) - 3'(pop);
    issue = (state_q == StFetch) && (occ < 3'd2);
  end

  always_comb begin : datapath
    addr_d      = addr_q;
    rd_vld_d    = issue;
    rd_addr_d   = rd_addr_q;
    fifo_data_d = fifo_data_q;
    fifo_addr_d = fifo_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + 2'(rd_vld_q) - 2'(pop);

    if (state_q == StFin) begin
      addr_d = '0;
    end else if (issue) begin
      addr_d    = addr_q + 1'b1;
      rd_addr_d = addr_q;
    end

    if (rd_vld_q) begin
      fifo_data_d[wr_ptr_q] = mem_rdata;
      fifo_addr_d[wr_ptr_q] = rd_addr_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin : datapath_reg
    if (rst) begin
      addr_q      <= '0;
      rd_vld_q    <= 1'b0;
      rd_addr_q   <= '0;
      fifo_data_q <= '{default: '0};
      fifo_addr_q <= '{default: '0};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      addr_q      <= addr_d;
      rd_vld_q    <= rd_vld_d;
      rd_addr_q   <= rd_addr_d;
      fifo_data_q <= fifo_data_d;
      fifo_addr_q <= fifo_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Tags are decoded from the head word's address; everything reads zero while no word is held.
  always_comb begin : tag_decode
    out_valid    = (count_q != 2'd0);
    head_addr    = fifo_addr_q[rd_ptr_q];
    out_data     = '0;
    out_seg      = 2'd0;
    out_idx      = '0;
    out_seg_last = 1'b0;
    out_last     = 1'b0;
    if (out_valid) begin
      out_data = fifo_data_q[rd_ptr_q];
      if (head_addr < SegBase1) begin
        out_seg      = 2'd0;
        out_idx      = 11'(head_addr);
        out_seg_last = (head_addr == SegBase1 - 1'b1);
      end else if (head_addr < SegBase2) begin
        out_seg      = 2'd1;
        out_idx      = 11'(head_addr - SegBase1);
        out_seg_last = (head_addr == SegBase2 - 1'b1);
      end else begin
        out_seg      = 2'd2;
        out_idx      = 11'(head_addr - SegBase2);
        out_seg_last = (head_addr == LastAddr);
        out_last     = (head_addr == LastAddr);
      end
    end
  end

endmodule

// File: tb/tb_gru_param_reader.sv
// Directed-sequence bench for gru_param_reader with a reference model of the stream layout and a
// memory model returning read data one cycle after each strobe.
module tb_gru_param_reader;

  localparam int NB    = 72;
  localparam int NI    = 1728;
  localparam int NR    = 1728;
  localparam int TOTAL = NB + NI + NR;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, mem_rd_en;
  logic [11:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_seg;
  logic [10:0] out_idx;
  logic        out_seg_last, out_last;

  logic [31:0] mem [0:4095];

  int n_cmp = 0;
  int n_err = 0;
  int exp_pos = 0;
  int issued = 0;
  int done_cnt = 0;
  logic done_exp = 1'b0;
  logic hold_pend = 1'b0;
  logic gap_en = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  gru_param_reader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_seg      (out_seg),
    .out_idx      (out_idx),
    .out_seg_last (out_seg_last),
    .out_last     (out_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (word %0d)", tag, obs, exp, exp_pos);
    end
  endtask

  // Stream position a -> segment tag, index within segment, segment-last, stream-last.
  task automatic model(input int a, output logic [1:0] s, output int i, output logic sl,
                       output logic l);
    int size;
    if (a < NB) begin
      s = 2'd0; i = a; size = NB;
    end else if (a < NB + NI) begin
      s = 2'd1; i = a - NB; size = NI;
    end else begin
      s = 2'd2; i = a - NB - NI; size = NR;
    end
    sl = (i == size - 1);
    l  = (a == TOTAL - 1);
  endtask

  task automatic tick(input logic rdy, input logic st, input logic r);
    logic [1:0] es;
    int ei;
    logic esl, el, hs;
    @(posedge clk);
    #1;
    out_ready = rdy;
    start     = st;
    rst       = r;
    @(negedge clk);
    if (done) done_cnt++;
    chk("done", done, done_exp);
    if (!r && hold_pend) chk("valid_hold", out_valid, 1);
    hs = out_valid && out_ready && !r;
    if (out_valid && !r) begin
      if (exp_pos >= TOTAL) begin
        chk("extra_word_pos", exp_pos, TOTAL - 1);
      end else begin
        model(exp_pos, es, ei, esl, el);
        chk("data", out_data, mem[exp_pos]);
        chk("seg", out_seg, es);
        chk("idx", out_idx, ei);
        chk("seg_last", out_seg_last, esl);
        chk("last", out_last, el);
      end
    end
    if (gap_en && !r && exp_pos > 0 && exp_pos < TOTAL) chk("gap", out_valid, 1);
    done_exp  = hs && (exp_pos == TOTAL - 1);
    hold_pend = out_valid && !out_ready && !r;
    if (hs) exp_pos++;
    if (mem_rd_en && !r) begin
      chk("rd_addr", mem_addr, issued);
      issued++;
      chk("outstanding", (issued - exp_pos) <= 2, 1);
    end
  endtask

  task automatic stream(input int stop, input int mode, input int budget);
    int n = 0;
    while (exp_pos < stop && n < budget) begin
      tick((mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode), 1'b0, 1'b0);
      n++;
    end
    chk("stream_end", exp_pos, stop);
  endtask

  task automatic restart_model();
    exp_pos   = 0;
    issued    = 0;
    done_exp  = 1'b0;
    hold_pend = 1'b0;
  endtask

  initial begin
    int d0;
    for (int a = 0; a < 4096; a++) mem[a] = 32'(a);

    // Reset state
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_tags", {out_data, out_seg, out_idx, out_seg_last, out_last}, 0);

    // Latency and full stream at full rate, with start re-asserted mid-stream and in FIN
    tick(1'b1, 1'b1, 1'b0);
    chk("lat_idle_busy", busy, 0);
    tick(1'b1, 1'b0, 1'b0);
    chk("lat_rd_en", mem_rd_en, 1);
    chk("lat_addr", mem_addr, 0);
    chk("lat_busy", busy, 1);
    tick(1'b1, 1'b0, 1'b0);
    chk("lat_valid_c2", out_valid, 0);
    tick(1'b1, 1'b0, 1'b0);
    chk("lat_valid_c3", out_valid, 1);
    gap_en = 1'b1;
    stream(100, 1, 500);
    tick(1'b1, 1'b1, 1'b0);
    stream(TOTAL, 1, 5000);
    gap_en = 1'b0;
    tick(1'b1, 1'b1, 1'b0);
    chk("fin_busy", busy, 1);
    tick(1'b1, 1'b0, 1'b0);
    chk("after_fin_busy", busy, 0);
    chk("after_fin_rd_en", mem_rd_en, 0);
    chk("done_pulses_1", done_cnt, 1);

    // New stream from IDLE with a 10-cycle stall at word 500
    restart_model();
    tick(1'b1, 1'b1, 1'b0);
    stream(500, 1, 1000);
    repeat (10) tick(1'b0, 1'b0, 1'b0);
    chk("stall_pos", exp_pos, 500);
    chk("stall_data", out_data, 500);
    stream(TOTAL, 1, 5000);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("done_pulses_2", done_cnt, 2);
    chk("idle_busy_2", busy, 0);

    // Abort at word 1000 with a read in flight
    restart_model();
    tick(1'b1, 1'b1, 1'b0);
    stream(1000, 1, 2000);
    chk("abort_in_flight", mem_rd_en, 1);
    tick(1'b1, 1'b0, 1'b1);
    restart_model();
    tick(1'b1, 1'b0, 1'b0);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rd_en", mem_rd_en, 0);
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    chk("done_pulses_abort", done_cnt, 2);

    // Random memory contents, random backpressure
    for (int a = 0; a < TOTAL; a++) mem[a] = $urandom;
    d0 = done_cnt;
    tick(1'b1, 1'b1, 1'b0);
    stream(TOTAL, 2, 30000);
    repeat (3) tick(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    chk("done_pulses_rand", done_cnt - d0, 1);
    chk("rand_issued", issued, TOTAL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
